msx_mouse_port: RTL

Converts the per-packet X/Y movement deltas and button states from the PS/2 mouse decoder into the MSX joystick-port mouse protocol. The MSX side toggles the port strobe (pin 8) four times per read and takes the X and Y motion as four 4-bit nibbles. The block sits between the PS/2 mouse decoder and the joystick-port multiplexer. It accumulates motion between host reads, serves nibbles in sequence, and recovers the read phase after a strobe timeout.

---
 rtl/msx_mouse_pkg.sv | 38 +++
 rtl/msx_mouse_port_sat_acc8.sv | 53 +++++
 rtl/msx_mouse_port.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/msx_mouse_pkg.sv
// ----------------------------------------------------------------------------
// msx_mouse_pkg
// Shared definitions for the MSX joystick-port mouse adapter:
//   - phase_e     : read-phase encoding (IDLE, X high, X low, Y high, Y low)
//   - TIMEOUT_CYC : clocks without a strobe edge before a read is abandoned
//   - phase_nibble: selects the nibble presented on the port for a phase
// ----------------------------------------------------------------------------
package msx_mouse_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_XH   = 3'd1,
        PH_XL   = 3'd2,
        PH_YH   = 3'd3,
        PH_YL   = 3'd4
    } phase_e;

    // About 1.5 ms at 21.48 MHz; long enough that a slow BASIC read never
    // trips it, short enough that a lost read resynchronises quickly.
    localparam int TIMEOUT_CYC = 32768;

    // Nibble driven onto joystick pins 1..4 for a given phase and snapshot.
    function automatic logic [3:0] phase_nibble(input phase_e ph,
                                                input logic [7:0] sx,
                                                input logic [7:0] sy);
        logic [3:0] nib;
        nib = 4'h0;
        case (ph)
            PH_XH:   nib = sx[7:4];
            PH_XL:   nib = sx[3:0];
            PH_YH:   nib = sy[7:4];
            PH_YL:   nib = sy[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/msx_mouse_port_sat_acc8.sv
// ----------------------------------------------------------------------------
// sat_acc8
// 8-bit signed accumulator that saturates at -128 / +127.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart from zero this cycle (a simultaneous add still lands)
//   add        : add delta to the accumulator
//   delta[7:0] : signed two's-complement increment
//   acc[7:0]   : current accumulated value
// ----------------------------------------------------------------------------
module sat_acc8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] delta,
    output logic [7:0] acc
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [7:0] base;
    logic [8:0] sum;

    // Clear replaces the old value with zero rather than discarding the add,
    // so a packet arriving in the same cycle as a snapshot is not lost.
    // The sum is formed in 9 bits; a disagreement between the top two bits
    // means the true result left the 8-bit signed range and is clamped.
    always_comb begin
        base  = clr ? 8'h00 : acc_q;
        sum   = {base[7], base} + {delta[7], delta};
        acc_d = base;
        if (add) begin
            if (sum[8] != sum[7]) begin
                acc_d = sum[8] ? 8'h80 : 8'h7F;
            end else begin
                acc_d = sum[7:0];
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/msx_mouse_port.sv
// ----------------------------------------------------------------------------
// msx_mouse_port
// Turns PS/2 mouse packets into the MSX joystick-port mouse protocol. Motion
// is accumulated between host reads; each strobe edge (either direction)
// advances through the X-high, X-low, Y-high, Y-low nibbles. A snapshot of
// the accumulators is taken on the first edge of every read.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   port_en          : 1 = mouse mode; 0 = port idles high, motion discarded
//   pkt_done         : one-cycle pulse, mou_dx / mou_dy valid
//   mou_dx, mou_dy   : signed per-packet deltas
//   mou_btn_l_n/_r_n : buttons, active-low
//   strobe           : joystick pin 8, asynchronous
//   joy_dat[3:0]     : joystick pins 1..4
//   joy_trga_n/_trgb_n: triggers A/B, active-low
// ----------------------------------------------------------------------------
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       port_en,
    input  logic       pkt_done,
    input  logic [7:0] mou_dx,
    input  logic [7:0] mou_dy,
    input  logic       mou_btn_l_n,
    input  logic       mou_btn_r_n,
    input  logic       strobe,
    output logic [3:0] joy_dat,
    output logic       joy_trga_n,
    output logic       joy_trgb_n
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic          sync1_q, sync2_q, sync3_q;
    logic          strobe_edge;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    snap_x_q, snap_x_d;
    logic [7:0]    snap_y_q, snap_y_d;
    logic [3:0]    joy_dat_q, joy_dat_d;
    logic          trga_q, trga_d;
    logic          trgb_q, trgb_d;
    logic          take_snap;
    logic [7:0]    acc_x, acc_y;

    // Two accumulators share one clear/add control: a snapshot clears both,
    // and while the port is disabled they are held at zero.
    sat_acc8 u_acc_x (
        .clk   (clk),
        .reset (reset),
        .clr   (take_snap | ~port_en),
        .add   (pkt_done & port_en),
        .delta (mou_dx),
        .acc   (acc_x)
    );

    sat_acc8 u_acc_y (
        .clk   (clk),
        .reset (reset),
        .clr   (take_snap | ~port_en),
        .add   (pkt_done & port_en),
        .delta (mou_dy),
        .acc   (acc_y)
    );

    assign strobe_edge = sync2_q ^ sync3_q;

    // Phase FSM, timeout counter, snapshot and output selection. A strobe
    // edge has priority over the timeout so a read that arrives just as the
    // counter expires still advances. Outputs are computed from the next
    // phase so the new nibble is registered on the same edge the phase moves.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        snap_x_d  = snap_x_q;
        snap_y_d  = snap_y_q;
        take_snap = 1'b0;

        if (!port_en) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else if (strobe_edge) begin
            cnt_d = '0;
            case (phase_q)
                PH_IDLE, PH_YL: begin
                    phase_d   = PH_XH;
                    take_snap = 1'b1;
                end
                PH_XH:   phase_d = PH_XL;
                PH_XL:   phase_d = PH_YH;
                PH_YH:   phase_d = PH_YL;
                default: phase_d = PH_IDLE;
            endcase
        end else if (phase_q == PH_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (take_snap) begin
            snap_x_d = acc_x;
            snap_y_d = acc_y;
        end

        if (port_en) begin
            joy_dat_d = phase_nibble(phase_d, snap_x_d, snap_y_d);
            trga_d    = mou_btn_l_n;
            trgb_d    = mou_btn_r_n;
        end else begin
            joy_dat_d = 4'hF;
            trga_d    = 1'b1;
            trgb_d    = 1'b1;
        end
    end

    // Strobe synchroniser (two stages) plus a delayed copy for edge detect,
    // and all state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            snap_x_q  <= 8'h00;
            snap_y_q  <= 8'h00;
            joy_dat_q <= 4'h0;
            trga_q    <= 1'b1;
            trgb_q    <= 1'b1;
        end else begin
            sync1_q   <= strobe;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            snap_x_q  <= snap_x_d;
            snap_y_q  <= snap_y_d;
            joy_dat_q <= joy_dat_d;
            trga_q    <= trga_d;
            trgb_q    <= trgb_d;
        end
    end

    assign joy_dat    = joy_dat_q;
    assign joy_trga_n = trga_q;
    assign joy_trgb_n = trgb_q;

endmodule
